tt_stream_loader: RTL and testbench

- Upstream feeder for the combinational N-point Mobius butterfly network.
- Accepts a Boolean function's truth table as a stream of W-bit words with a valid/ready handshake and assembles it into an N-bit register.
- Presents the assembled frame to the transform with a valid/ready handshake and holds it stable until accepted.
- Single-buffered; detects framing errors using an end-of-frame marker.

---
 rtl/mobius_pkg.sv | 19 +
 rtl/tt_stream_loader_if.sv | 41 ++++
 rtl/popcount_w.sv | 19 +
 rtl/tt_stream_loader.sv | 114 +++++++++++
 tb/tb_tt_stream_loader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mobius_pkg.sv
// Shared types and sizing helpers for the Mobius transform front end.
package mobius_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } loader_state_e;

  localparam int DEF_N      = 2048;
  localparam int DEF_LOG2_N = 11;
  localparam int DEF_W      = 32;
  localparam int DEF_LOG2_W = 5;

  // Word counter width; a single-word frame still needs a 1-bit counter.
  function automatic int cnt_width(input int log2_n, input int log2_w);
    return ((log2_n - log2_w) < 1) ? 1 : (log2_n - log2_w);
  endfunction

endpackage

// File: rtl/tt_stream_loader_if.sv
// Word-stream input and frame output bundle of the truth-table loader.
// tt_weight exists only when TT_LOADER_WEIGHT_EN is defined.
interface tt_stream_loader_if #(
  parameter int N = 2048,
  parameter int W = 32
);

  logic         flush;
  logic [0:W-1] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [0:N-1] tt_out;
  logic         out_valid;
  logic         out_ready;
  logic         frame_err;

`ifdef TT_LOADER_WEIGHT_EN
  localparam int LOG2_N = $clog2(N);
  logic [LOG2_N:0] tt_weight;

  modport slave (
    input  flush, in_data, in_valid, in_last, out_ready,
    output in_ready, tt_out, out_valid, frame_err, tt_weight
  );
  modport master (
    output flush, in_data, in_valid, in_last, out_ready,
    input  in_ready, tt_out, out_valid, frame_err, tt_weight
  );
`else
  modport slave (
    input  flush, in_data, in_valid, in_last, out_ready,
    output in_ready, tt_out, out_valid, frame_err
  );
  modport master (
    output flush, in_data, in_valid, in_last, out_ready,
    input  in_ready, tt_out, out_valid, frame_err
  );
`endif

endinterface

// File: rtl/popcount_w.sv
// Combinational population count of one W-bit word; zero latency, no handshake.
module popcount_w #(
  parameter int W      = 32,
  parameter int LOG2_W = 5
) (
  input  logic [0:W-1]    data,
  output logic [LOG2_W:0] count
);

  localparam int CW = LOG2_W + 1;

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/tt_stream_loader.sv
// Assembles W-bit words into an N-bit truth table; out_valid 1 cycle after the last word,
// frame held until out_ready, no words taken while full. Optional TT_LOADER_WEIGHT_EN adds tt_weight.
module tt_stream_loader
  import mobius_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int LOG2_N = DEF_LOG2_N,
  parameter int W      = DEF_W,
  parameter int LOG2_W = DEF_LOG2_W
) (
  input logic          clk,
  input logic          rst_n,
  tt_stream_loader_if.slave io
);

  localparam int CNT_W = cnt_width(LOG2_N, LOG2_W);
  localparam int WORDS = N / W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:N-1]     tt_q;
  logic             err_q, err_d;
  logic             accept;
  logic             last_word;

  assign io.in_ready  = (state_q == LOAD) && !io.flush;
  assign accept       = io.in_valid && io.in_ready;
  assign last_word    = (cnt_q == LAST_CNT);
  assign io.tt_out    = tt_q;
  assign io.out_valid = (state_q == FULL);
  assign io.frame_err = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (io.flush) begin
      state_d = LOAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (last_word && io.in_last) begin
              state_d = FULL;
              cnt_d   = '0;
            end else if (last_word || io.in_last) begin
              // Early or missing end marker: the word is consumed and the frame restarts.
              err_d = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (io.out_ready) begin
            state_d = LOAD;
            cnt_d   = '0;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        for (int k = 0; k < WORDS; k++) begin
          if (cnt_q == CNT_W'(k)) tt_q[k*W +: W] <= io.in_data;
        end
      end
    end
  end

`ifdef TT_LOADER_WEIGHT_EN
  localparam int WT_W = LOG2_N + 1;

  logic [LOG2_W:0] word_pop;
  logic [LOG2_N:0] weight_q;

  popcount_w #(
    .W     (W),
    .LOG2_W(LOG2_W)
  ) u_popcount (
    .data (io.in_data),
    .count(word_pop)
  );

  // The first word of a frame restarts the sum, so the previous total survives the hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
    end else if (io.flush || err_d) begin
      weight_q <= '0;
    end else if (accept) begin
      weight_q <= ((cnt_q == '0) ? '0 : weight_q) + WT_W'(word_pop);
    end
  end

  assign io.tt_weight = weight_q;
`endif

endmodule

// File: tb/tb_tt_stream_loader.sv
// Directed bench for tt_stream_loader at N=16, W=4.
module tb_tt_stream_loader;

  localparam int N = 16;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  tt_stream_loader_if #(.N(N), .W(W)) bus ();

  tt_stream_loader #(
    .N     (N),
    .LOG2_N(4),
    .W     (W),
    .LOG2_W(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  always #5 clk = ~clk;

  // Reference Mobius (ANF) transform used to check the frame as the transform would see it.
  function automatic logic [0:15] anf(input logic [0:15] f);
    logic [0:15] a;
    a = f;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 16; k++)
        if ((k & (1 << s)) != 0) a[k] = a[k] ^ a[k ^ (1 << s)];
    return a;
  endfunction

  task automatic send(input logic [0:3] d, input logic l);
    @(negedge clk);
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic handoff();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.flush = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0;
    bus.in_last = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    n_checks++; if (bus.tt_out !== 16'h0000) begin n_fail++; $display("FAIL reset_tt_out: got %h expected 0000", bus.tt_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [0:15] exp, tr;
    exp = 16'b1000_0000_0000_0001;
    send(4'b1000, 1'b0);
    send(4'b0000, 1'b0);
    send(4'b0000, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL frame_early_valid: got %b expected 0", bus.out_valid); end
    send(4'b0001, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL frame_out_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL frame_in_ready: got %b expected 0", bus.in_ready); end
    n_checks++; if (bus.tt_out !== exp) begin n_fail++; $display("FAIL frame_tt_out: got %b expected %b", bus.tt_out, exp); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_err_clean: got %b expected 0", bus.frame_err); end
    tr = anf(bus.tt_out);
    n_checks++; if (tr[15] !== 1'b0) begin n_fail++; $display("FAIL frame_anf15: got %b expected 0", tr[15]); end
    n_checks++; if (tr[0] !== 1'b1) begin n_fail++; $display("FAIL frame_anf0: got %b expected 1", tr[0]); end
`ifdef TT_LOADER_WEIGHT_EN
    n_checks++; if (bus.tt_weight !== 5'd2) begin n_fail++; $display("FAIL frame_weight: got %0d expected 2", bus.tt_weight); end
`endif
    handoff();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL handoff_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL handoff_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_backpressure();
    logic [0:15] exp;
    exp = 16'b0110_1111_0000_1010;
    send(4'b0110, 1'b0);
    send(4'b1111, 1'b0);
    send(4'b0000, 1'b0);
    send(4'b1010, 1'b1);
`ifdef TT_LOADER_WEIGHT_EN
    n_checks++; if (bus.tt_weight !== 5'd8) begin n_fail++; $display("FAIL bp_weight: got %0d expected 8", bus.tt_weight); end
`endif
    @(negedge clk);
    bus.in_data = 4'b1111; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.tt_out !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got tt=%b rdy=%b vld=%b expected tt=%b rdy=0 vld=1",
                 c, bus.tt_out, bus.in_ready, bus.out_valid, exp);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    handoff();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_early_last();
    logic [0:15] exp;
    exp = 16'b0001_0010_0100_1000;
    send(4'b1100, 1'b0);
    send(4'b0011, 1'b1);
    n_checks++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL early_err_pulse: got %b expected 1", bus.frame_err); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL early_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL early_out_valid: got %b expected 0", bus.out_valid); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL early_err_once: got %b expected 0", bus.frame_err); end
    send(4'b0001, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b0100, 1'b0);
    send(4'b1000, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL early_next_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.tt_out !== exp) begin n_fail++; $display("FAIL early_next_tt: got %b expected %b", bus.tt_out, exp); end
    handoff();
  endtask

  task automatic test_missing_last();
    logic [0:15] exp;
    exp = 16'b1010_0101_1010_0101;
    send(4'b1111, 1'b0);
    send(4'b1111, 1'b0);
    send(4'b1111, 1'b0);
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL missing_no_early_err: got %b expected 0", bus.frame_err); end
    send(4'b1111, 1'b0);
    n_checks++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL missing_err_pulse: got %b expected 1", bus.frame_err); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL missing_out_valid: got %b expected 0", bus.out_valid); end
    send(4'b1010, 1'b0);
    send(4'b0101, 1'b0);
    send(4'b1010, 1'b0);
    send(4'b0101, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL missing_next_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.tt_out !== exp) begin n_fail++; $display("FAIL missing_next_tt: got %b expected %b", bus.tt_out, exp); end
    handoff();
  endtask

  task automatic test_flush();
    logic [0:15] exp;
    exp = 16'b0011_1100_0110_1001;
    send(4'b1111, 1'b0);
    send(4'b1111, 1'b0);
    @(negedge clk);
    bus.flush = 1'b1; bus.in_data = 4'b0000; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL flush_no_err: got %b expected 0", bus.frame_err); end
    send(4'b0011, 1'b0);
    send(4'b1100, 1'b0);
    send(4'b0110, 1'b0);
    send(4'b1001, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_next_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.tt_out !== exp) begin n_fail++; $display("FAIL flush_next_tt: got %b expected %b", bus.tt_out, exp); end
  endtask

  task automatic test_async_reset();
    logic [0:15] exp;
    exp = 16'b1000_0100_0010_0001;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.tt_out !== 16'h0000) begin n_fail++; $display("FAIL arst_tt_out: got %b expected 0", bus.tt_out); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    send(4'b1111, 1'b0);
    send(4'b1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    send(4'b1000, 1'b0);
    send(4'b0100, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b0001, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_next_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.tt_out !== exp) begin n_fail++; $display("FAIL arst_next_tt: got %b expected %b", bus.tt_out, exp); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL arst_next_err: got %b expected 0", bus.frame_err); end
    handoff();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
